serial_magnitude_comparator: RTL
================================

# serial_magnitude_comparator

Parametrised, bit-serial magnitude comparator. It captures two WIDTH-bit operands on a start handshake and compares them MSB-first, one bit per clock. It reports registered less/equal/greater flags with a one-cycle done pulse, and can optionally terminate early and compare in two's complement. It is the sequential, multi-bit successor to the 1-bit comparator and serves area-constrained datapaths where a parallel comparator is too large.

## Interface
Parameters:
- WIDTH, 8, operand width in bits; legal range 2..64.
- SIGNED, 0, 1 = operands are two's complement; 0 = unsigned.
- EARLY_EXIT, 1, 1 = finish on the first differing bit; 0 = always examine all WIDTH bits.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only when busy=0.
- a  input  WIDTH  operand A; sampled on the accepting edge only.
- b  input  WIDTH  operand B; sampled on the accepting edge only.
- busy  output  1  comparison in progress.
- done  output  1  one-cycle pulse; l/e/g are valid and updated.
- l  output  1  A < B.
- e  output  1  A == B.
- g  output  1  A > B.

## Operation
- States: IDLE and CMP.
- IDLE with start=1 at an edge:
  - Load a_q←a and b_q←b.
  - Set idx←WIDTH-1 and busy←1.
  - Go to CMP.
- IDLE with start=0: hold all state.
- CMP, each edge: examine a_q[idx] and b_q[idx].
  - Bits differ, idx==WIDTH-1, SIGNED=1: the operand with bit=1 is the smaller one.
  - Bits differ, all other cases: the operand with bit=1 is the larger one.
  - Bits differ and EARLY_EXIT=1: finish now.
  - Bits differ and EARLY_EXIT=0: latch the first difference into a sticky decision and continue.
  - idx==0: finish. With no difference found, the result is e=1.
  - Otherwise: idx←idx-1.
- Finish:
  - Write exactly one of l/e/g as 1.
  - done←1 for one cycle.
  - busy←0.
  - Return to IDLE.
- l/e/g hold their last result until the next finish. They are never all 1, and never more than one is 1.
- start while busy=1 is ignored and has no side effect. a/b may change freely while busy.
- Reset values: busy=0, done=0, l=0, e=0, g=0, state=IDLE. l=e=g=0 means "no result yet".
- idx is a $clog2(WIDTH)-bit down-counter. It never wraps, because finish is forced at idx==0.

## Timing
- The accepting edge is E0. busy=1 from E0 until the finish edge.
- Full-length comparison: finish on edge E0+WIDTH. done is high in the cycle following that edge.
- Early exit on bit k (MSB = WIDTH-1): finish on edge E0+(WIDTH-k). Minimum latency is 1 edge.
- Back-to-back operation: on the finish edge the FSM is already in IDLE and busy=0. A start sampled on the next edge, i.e. during the done cycle, is accepted. Throughput is one comparison per latency+1 cycles.
- done and the updated l/e/g appear together in the same cycle. There is no combinational path from the inputs to any output.
- rst_n low at any time, including mid-CMP:
  - All outputs take their reset values immediately, asynchronously.
  - The in-flight comparison is discarded.
  - No done pulse is produced on reset release.
- Reset deassertion is synchronised externally. The block requires rst_n to be released away from a clk edge.

## Structure
- Package comparator_pkg:
  - State enum: IDLE, CMP.
  - Result encoding constants: RES_NONE, RES_LT, RES_EQ, RES_GT, as a 2-bit code.
  - Function for counter width: clog2.
- Sub-module bit_compare_cell: a combinational single-bit compare.
  - Inputs: a_bit, b_bit, is_msb, signed_mode.
  - Outputs: diff and a_gt.
  - Instantiated once inside the FSM datapath.
- Top level: FSM, operand registers, idx counter, sticky decision register, output registers.

## Test plan
1. Equal operands, WIDTH=8, SIGNED=0, EARLY_EXIT=1: a=0x5A, b=0x5A → done exactly 8 edges after accept; l=0, e=1, g=0; busy low in the done cycle.
2. MSB difference, early exit: a=0x80, b=0x7F.
   - SIGNED=0 → done 1 edge after accept, g=1.
   - SIGNED=1 → done 1 edge after accept, l=1 (-128 < 127).
3. LSB-only difference: a=0x12, b=0x13 → done after 8 edges, l=1.
   - Repeat with EARLY_EXIT=0 and a=0xF0, b=0x70 → still 8 edges, g=1 (unsigned).
4. Protocol:
   - Pulse start with a=0x01, b=0x02 at edge 3 of a busy period → ignored; the original result is unaffected.
   - Assert start during the done cycle with a=0x03, b=0x03 → accepted; a second done appears with e=1.
5. Reset mid-operation: assert rst_n=0 at 3 cycles into an 8-cycle compare → busy, done, l, e, g all 0 immediately; after release, no done pulse until a new start.
6. Sweep WIDTH=2 and WIDTH=16 with random operand pairs against a reference compare, for SIGNED in {0,1} → results always match; exactly one flag set at each done; latency ≤ WIDTH.

Source files
------------

// File: rtl/comparator_pkg.sv
// Shared types, result encoding and helpers for the bit-serial magnitude comparator.
// The 2-bit result code is the single source of the one-hot l/e/g flags.
package comparator_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      CMP  = 1'b1
   } state_t;

   localparam logic [1:0] RES_NONE = 2'd0;
   localparam logic [1:0] RES_LT   = 2'd1;
   localparam logic [1:0] RES_EQ   = 2'd2;
   localparam logic [1:0] RES_GT   = 2'd3;

   // Smallest r with 2**r >= value; WIDTH is at least 2, so this never returns 0.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(value)) begin
            r = i + 1;
         end else begin
            r = r;
         end
      end
      return r;
   endfunction

   // Expands a result code into {l, e, g}; RES_NONE maps to "no result yet".
   function automatic logic [2:0] res_to_flags(input logic [1:0] res);
      logic [2:0] flags;
      case (res)
         RES_LT:  flags = 3'b100;
         RES_EQ:  flags = 3'b010;
         RES_GT:  flags = 3'b001;
         default: flags = 3'b000;
      endcase
      return flags;
   endfunction

   // Folds the sticky first-difference decision into a result code.
   function automatic logic [1:0] gt_to_res(input logic a_gt);
      logic [1:0] res;
      if (a_gt) begin
         res = RES_GT;
      end else begin
         res = RES_LT;
      end
      return res;
   endfunction

endpackage

// File: rtl/bit_compare_cell.sv
// Single-bit compare: flags a difference and says whether A's bit makes A larger.
// On the sign bit of a two's-complement operand the sense is inverted.
module bit_compare_cell (
   input  logic a_bit,
   input  logic b_bit,
   input  logic is_msb,
   input  logic signed_mode,
   output logic diff,
   output logic a_gt
);

   // A set sign bit means a negative value, so the operand holding it is the smaller one.
   always_comb begin
      diff = a_bit ^ b_bit;
      a_gt = diff & (a_bit ^ (is_msb & signed_mode));
   end

endmodule

// File: rtl/serial_magnitude_comparator.sv
// Bit-serial MSB-first magnitude comparator with optional early exit and signed mode.
// Operands are captured on the accepting edge; results are registered with a done pulse.
module serial_magnitude_comparator
   import comparator_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int SIGNED     = 0,
   parameter int EARLY_EXIT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             l,
   output logic             e,
   output logic             g
);

   localparam int            IW       = clog2(WIDTH);
   localparam logic [IW-1:0] IDX_MSB  = IW'(WIDTH - 1);
   localparam logic          SIGNED_C = (SIGNED != 0);
   localparam logic          EARLY_C  = (EARLY_EXIT != 0);

   state_t           state_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [IW-1:0]    idx_q;
   logic             found_q;
   logic             found_gt_q;
   logic             busy_q;
   logic             done_q;
   logic             l_q;
   logic             e_q;
   logic             g_q;

   logic             diff_s;
   logic             a_gt_s;
   logic             is_msb_s;
   logic             finish_d;
   logic [1:0]       res_d;
   logic [2:0]       flags_d;

   assign is_msb_s = (idx_q == IDX_MSB);

   bit_compare_cell u_cell (
      .a_bit       (a_q[idx_q]),
      .b_bit       (b_q[idx_q]),
      .is_msb      (is_msb_s),
      .signed_mode (SIGNED_C),
      .diff        (diff_s),
      .a_gt        (a_gt_s)
   );

   // Finish decision and result for the bit under examination this cycle.
   always_comb begin
      finish_d = 1'b0;
      res_d    = RES_NONE;
      if (state_q == CMP) begin
         if (diff_s && EARLY_C) begin
            finish_d = 1'b1;
            res_d    = gt_to_res(a_gt_s);
         end else if (idx_q == '0) begin
            finish_d = 1'b1;
            if (found_q) begin
               res_d = gt_to_res(found_gt_q);
            end else if (diff_s) begin
               res_d = gt_to_res(a_gt_s);
            end else begin
               res_d = RES_EQ;
            end
         end else begin
            finish_d = 1'b0;
            res_d    = RES_NONE;
         end
      end else begin
         finish_d = 1'b0;
         res_d    = RES_NONE;
      end
      flags_d = res_to_flags(res_d);
   end

   // Control FSM, operand capture, index countdown, sticky decision and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         a_q        <= '0;
         b_q        <= '0;
         idx_q      <= '0;
         found_q    <= 1'b0;
         found_gt_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         l_q        <= 1'b0;
         e_q        <= 1'b0;
         g_q        <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  a_q        <= a;
                  b_q        <= b;
                  idx_q      <= IDX_MSB;
                  found_q    <= 1'b0;
                  found_gt_q <= 1'b0;
                  busy_q     <= 1'b1;
                  state_q    <= CMP;
               end
            end
            CMP: begin
               if (finish_d) begin
                  {l_q, e_q, g_q} <= flags_d;
                  done_q          <= 1'b1;
                  busy_q          <= 1'b0;
                  state_q         <= IDLE;
               end else begin
                  // Only the most significant difference decides; later ones are ignored.
                  if (diff_s && !found_q) begin
                     found_q    <= 1'b1;
                     found_gt_q <= a_gt_s;
                  end
                  idx_q <= idx_q - IW'(1);
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign l    = l_q;
   assign e    = e_q;
   assign g    = g_q;

endmodule
